// File: rtl/inv_clarke_ab2abc_pkg.sv
// Shared definitions for the Clarke / inverse-Clarke blocks: Q8.24 constants,
// FSM state encoding and fixed-point round/saturate helpers.
package inv_clarke_ab2abc_pkg;

   // Widest intermediate the helpers handle (product of two 32-bit samples plus a guard bit).
   localparam int MAX_W = 64;

   localparam logic signed [31:0] K_RTSD    = 32'sd14529495;   // sqrt(3)/2
   localparam logic signed [31:0] K_ONEHALF = 32'sd8388608;    // 1/2
   localparam logic signed [31:0] K_DST     = 32'sd11184810;   // 2/3

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_SUM  = 2'b10,
      ST_HOLD = 2'b11
   } state_e;

   function automatic logic signed [MAX_W:0] round_shift(input logic signed [MAX_W:0] x,
                                                         input int                    fp);
      logic signed [MAX_W:0] bias;
      if (fp > 0) begin
         bias = 65'sd1 <<< (fp - 1);
      end else begin
         bias = 65'sd0;
      end
      return (x + bias) >>> fp;
   endfunction

   // True when x does not fit in a w-bit two's complement word.
   function automatic logic sat_hit(input logic signed [MAX_W:0] x, input int w);
      logic signed [MAX_W:0] hi;
      logic signed [MAX_W:0] lo;
      hi = (65'sd1 <<< (w - 1)) - 65'sd1;
      lo = -(65'sd1 <<< (w - 1));
      return (x > hi) || (x < lo);
   endfunction

endpackage

// File: rtl/inv_clarke_ab2abc_qmult_rs.sv
// Signed Q-format multiplier: full-width product, round-half-up, then
// saturation back to DATA_WIDTH with a clip flag.
module qmult_rs
   import inv_clarke_ab2abc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FP_WIDTH   = 24
) (
   input  logic signed [DATA_WIDTH-1:0] a_i,
   input  logic signed [DATA_WIDTH-1:0] b_i,
   output logic signed [DATA_WIDTH-1:0] p_o,
   output logic                         sat_o
);

   logic signed [2*DATA_WIDTH-1:0] prod_s;
   logic signed [MAX_W:0]          prod_ext_s;
   logic signed [MAX_W:0]          rnd_s;

   assign prod_s     = a_i * b_i;
   assign prod_ext_s = {{(MAX_W + 1 - 2*DATA_WIDTH){prod_s[2*DATA_WIDTH-1]}}, prod_s};
   assign rnd_s      = round_shift(prod_ext_s, FP_WIDTH);
   assign sat_o      = sat_hit(rnd_s, DATA_WIDTH);

   // Clip to the nearest rail on overflow, otherwise pass the rounded value through.
   always_comb begin
      p_o = rnd_s[DATA_WIDTH-1:0];
      if (sat_o) begin
         p_o = {rnd_s[MAX_W], {(DATA_WIDTH-1){~rnd_s[MAX_W]}}};
      end else begin
         p_o = rnd_s[DATA_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/inv_clarke_ab2abc.sv
// Inverse Clarke transform (alpha/beta -> a/b/c), one sample in flight,
// IDLE -> MUL -> SUM -> HOLD with a single shared K*beta multiplier.
module inv_clarke_ab2abc
   import inv_clarke_ab2abc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FP_WIDTH   = 24
) (
   input  logic                         Clk,
   input  logic                         Resetn,
   input  logic signed [DATA_WIDTH-1:0] alpha,
   input  logic signed [DATA_WIDTH-1:0] beta,
   input  logic                         in_data_valid,
   output logic                         in_data_ready,
   output logic signed [DATA_WIDTH-1:0] phase_a,
   output logic signed [DATA_WIDTH-1:0] phase_b,
   output logic signed [DATA_WIDTH-1:0] phase_c,
   output logic                         sat,
   output logic                         out_data_valid,
   input  logic                         out_data_ready
);

   localparam logic signed [DATA_WIDTH-1:0] K_COEF = DATA_WIDTH'(K_RTSD);

   state_e                        state_q,     state_d;
   logic                          in_ready_q,  in_ready_d;
   logic                          out_valid_q, out_valid_d;
   logic signed [DATA_WIDTH-1:0]  alpha_q,     alpha_d;
   logic signed [DATA_WIDTH-1:0]  beta_q,      beta_d;
   logic signed [DATA_WIDTH-1:0]  half_q,      half_d;
   logic signed [DATA_WIDTH-1:0]  kb_q,        kb_d;
   logic                          ksat_q,      ksat_d;
   logic signed [DATA_WIDTH-1:0]  pa_q,        pa_d;
   logic signed [DATA_WIDTH-1:0]  pb_q,        pb_d;
   logic signed [DATA_WIDTH-1:0]  pc_q,        pc_d;
   logic                          sat_q,       sat_d;

   logic signed [DATA_WIDTH-1:0]  kb_s;
   logic                          ksat_s;
   logic signed [DATA_WIDTH:0]    sum_b_s;
   logic signed [DATA_WIDTH:0]    sum_c_s;
   logic signed [MAX_W:0]         sum_b_ext_s;
   logic signed [MAX_W:0]         sum_c_ext_s;
   logic                          clip_b_s;
   logic                          clip_c_s;
   logic signed [DATA_WIDTH-1:0]  b_sat_s;
   logic signed [DATA_WIDTH-1:0]  c_sat_s;

   qmult_rs #(
      .DATA_WIDTH (DATA_WIDTH),
      .FP_WIDTH   (FP_WIDTH)
   ) u_kbeta (
      .a_i   (beta_q),
      .b_i   (K_COEF),
      .p_o   (kb_s),
      .sat_o (ksat_s)
   );

   // One guard bit keeps -half +/- K*beta exact before clipping.
   assign sum_b_s     = {kb_q[DATA_WIDTH-1], kb_q} - {half_q[DATA_WIDTH-1], half_q};
   assign sum_c_s     = -{kb_q[DATA_WIDTH-1], kb_q} - {half_q[DATA_WIDTH-1], half_q};
   assign sum_b_ext_s = {{(MAX_W - DATA_WIDTH){sum_b_s[DATA_WIDTH]}}, sum_b_s};
   assign sum_c_ext_s = {{(MAX_W - DATA_WIDTH){sum_c_s[DATA_WIDTH]}}, sum_c_s};
   assign clip_b_s    = sat_hit(sum_b_ext_s, DATA_WIDTH);
   assign clip_c_s    = sat_hit(sum_c_ext_s, DATA_WIDTH);

   // Saturate the b/c sums to the DATA_WIDTH rails.
   always_comb begin
      b_sat_s = sum_b_s[DATA_WIDTH-1:0];
      c_sat_s = sum_c_s[DATA_WIDTH-1:0];
      if (clip_b_s) begin
         b_sat_s = {sum_b_s[DATA_WIDTH], {(DATA_WIDTH-1){~sum_b_s[DATA_WIDTH]}}};
      end else begin
         b_sat_s = sum_b_s[DATA_WIDTH-1:0];
      end
      if (clip_c_s) begin
         c_sat_s = {sum_c_s[DATA_WIDTH], {(DATA_WIDTH-1){~sum_c_s[DATA_WIDTH]}}};
      end else begin
         c_sat_s = sum_c_s[DATA_WIDTH-1:0];
      end
   end

   // Next-state and datapath load decisions for the sample FSM.
   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      alpha_d     = alpha_q;
      beta_d      = beta_q;
      half_d      = half_q;
      kb_d        = kb_q;
      ksat_d      = ksat_q;
      pa_d        = pa_q;
      pb_d        = pb_q;
      pc_d        = pc_q;
      sat_d       = sat_q;
      case (state_q)
         ST_IDLE: begin
            in_ready_d = 1'b1;
            if (in_data_valid && in_ready_q) begin
               alpha_d    = alpha;
               beta_d     = beta;
               in_ready_d = 1'b0;
               state_d    = ST_MUL;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_MUL: begin
            half_d  = alpha_q >>> 1;
            kb_d    = kb_s;
            ksat_d  = ksat_s;
            state_d = ST_SUM;
         end
         ST_SUM: begin
            pa_d        = alpha_q;
            pb_d        = b_sat_s;
            pc_d        = c_sat_s;
            sat_d       = clip_b_s | clip_c_s | ksat_q;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_data_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_HOLD;
            end
         end
         default: begin
            in_ready_d  = 1'b0;
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any sample in flight.
   always_ff @(posedge Clk) begin
      if (!Resetn) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         alpha_q     <= '0;
         beta_q      <= '0;
         half_q      <= '0;
         kb_q        <= '0;
         ksat_q      <= 1'b0;
         pa_q        <= '0;
         pb_q        <= '0;
         pc_q        <= '0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         alpha_q     <= alpha_d;
         beta_q      <= beta_d;
         half_q      <= half_d;
         kb_q        <= kb_d;
         ksat_q      <= ksat_d;
         pa_q        <= pa_d;
         pb_q        <= pb_d;
         pc_q        <= pc_d;
         sat_q       <= sat_d;
      end
   end

   assign in_data_ready  = in_ready_q;
   assign out_data_valid = out_valid_q;
   assign phase_a        = pa_q;
   assign phase_b        = pb_q;
   assign phase_c        = pc_q;
   assign sat            = sat_q;

endmodule

// File: tb/tb_inv_clarke_ab2abc.sv
// Bench for inv_clarke_ab2abc: directed cases plus random traffic, checked every
// cycle against an arithmetic model and an expected-output queue.
module tb_inv_clarke_ab2abc;

   logic        Clk = 1'b0;
   logic        Resetn = 1'b0;
   logic [31:0] alpha = 32'd0;
   logic [31:0] beta = 32'd0;
   logic        in_data_valid = 1'b0;
   logic        in_data_ready;
   logic [31:0] phase_a, phase_b, phase_c;
   logic        sat;
   logic        out_data_valid;
   logic        out_data_ready = 1'b0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        s;
      int          rdy;
   } exp_t;

   exp_t q[$];
   exp_t last_out;
   int   n_tests = 0;
   int   n_fail = 0;
   int   cnt = 0;
   int   n_out = 0;
   bit   rst_pend = 1'b1;

   inv_clarke_ab2abc dut (
      .Clk            (Clk),
      .Resetn         (Resetn),
      .alpha          (alpha),
      .beta           (beta),
      .in_data_valid  (in_data_valid),
      .in_data_ready  (in_data_ready),
      .phase_a        (phase_a),
      .phase_b        (phase_b),
      .phase_c        (phase_c),
      .sat            (sat),
      .out_data_valid (out_data_valid),
      .out_data_ready (out_data_ready)
   );

   always #5 Clk = ~Clk;

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // a = alpha; b,c = -floor(alpha/2) +/- round(K*beta), clipped to 32-bit signed
   function automatic exp_t model(input logic [31:0] al, input logic [31:0] be);
      exp_t   r;
      longint av, bv, half, kb, sb, sc;
      longint maxv, minv;
      maxv = 64'sd2147483647;
      minv = -64'sd2147483648;
      av   = longint'($signed(al));
      bv   = longint'($signed(be));
      half = (av - (av & 64'sd1)) / 64'sd2;
      kb   = (bv * 64'sd14529495 + 64'sd8388608) >>> 24;
      sb   = kb - half;
      sc   = -kb - half;
      r.a  = al;
      if (sb > maxv) r.b = 32'h7FFFFFFF;
      else if (sb < minv) r.b = 32'h80000000;
      else r.b = sb[31:0];
      if (sc > maxv) r.c = 32'h7FFFFFFF;
      else if (sc < minv) r.c = 32'h80000000;
      else r.c = sc[31:0];
      r.s   = (sb > maxv) || (sb < minv) || (sc > maxv) || (sc < minv);
      r.rdy = 0;
      return r;
   endfunction

   function automatic logic [31:0] rand_val();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0:       v = 32'h80000000;
         1:       v = 32'h7FFFFFFF;
         2:       v = 32'(int'($urandom_range(0, 65535)) - 32768);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   always @(posedge Clk) cnt <= cnt + 1;

   // Per-cycle scoreboard: handshakes, ready/valid timing and output values.
   always @(negedge Clk) begin : mon
      bit   exp_ov;
      bit   exp_ir;
      exp_t ex;
      exp_ov = (q.size() > 0) && (cnt >= q[0].rdy);
      exp_ir = !rst_pend && (q.size() == 0);
      check1("out_valid", out_data_valid, exp_ov);
      check1("in_ready", in_data_ready, exp_ir);
      if (exp_ov) ex = q[0];
      else ex = last_out;
      check32("phase_a", phase_a, ex.a);
      check32("phase_b", phase_b, ex.b);
      check32("phase_c", phase_c, ex.c);
      check1("sat", sat, ex.s);
      if (!Resetn) begin
         q.delete();
         last_out = '{32'd0, 32'd0, 32'd0, 1'b0, 0};
         rst_pend = 1'b1;
      end else begin
         rst_pend = 1'b0;
         if (exp_ov && out_data_ready) begin
            last_out = q.pop_front();
            n_out++;
         end
         if (in_data_valid && exp_ir) begin
            ex     = model(alpha, beta);
            ex.rdy = cnt + 3;
            q.push_back(ex);
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b);
      int g = 0;
      in_data_valid = 1'b1;
      alpha = a;
      beta  = b;
      while (!in_data_ready && g < 50) begin
         tick();
         g++;
      end
      check1("send_ready", in_data_ready, 1'b1);
      tick();
      in_data_valid = 1'b0;
   endtask

   task automatic wait_valid(input string nm, output int lat);
      lat = 0;
      while (!out_data_valid && lat < 20) begin
         tick();
         lat++;
      end
      check1({nm, "_valid"}, out_data_valid, 1'b1);
   endtask

   task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ea, input logic [31:0] eb,
                           input logic [31:0] ec, input logic es);
      int lat;
      send(a, b);
      wait_valid(nm, lat);
      check32({nm, "_latency"}, 32'(lat), 32'd2);
      check32({nm, "_a"}, phase_a, ea);
      check32({nm, "_b"}, phase_b, eb);
      check32({nm, "_c"}, phase_c, ec);
      check1({nm, "_sat"}, sat, es);
      tick();
      check1({nm, "_valid_drop"}, out_data_valid, 1'b0);
   endtask

   initial begin
      exp_t m;
      int   lat;
      int   base;
      bit   pending;
      bit   hs;
      last_out = '{32'd0, 32'd0, 32'd0, 1'b0, 0};

      m = model(32'h01000000, 32'h00000000);
      check32("model_t1_b", m.b, 32'hFF800000);
      check32("model_t1_c", m.c, 32'hFF800000);
      m = model(32'h00000000, 32'h01000000);
      check32("model_t2_b", m.b, 32'h00DDB3D7);
      check32("model_t2_c", m.c, 32'hFF224C29);
      m = model(32'h80000000, 32'h7FFFFFFF);
      check32("model_t3_b", m.b, 32'h7FFFFFFF);
      check32("model_t3_c", m.c, 32'hD1261481);
      check1("model_t3_sat", m.s, 1'b1);

      repeat (3) tick();
      check1("rst_in_ready", in_data_ready, 1'b0);
      check1("rst_out_valid", out_data_valid, 1'b0);
      check32("rst_phase_b", phase_b, 32'd0);
      Resetn = 1'b1;
      tick();
      check1("rel_in_ready", in_data_ready, 1'b1);

      out_data_ready = 1'b1;
      directed("t1", 32'h01000000, 32'h00000000, 32'h01000000, 32'hFF800000, 32'hFF800000, 1'b0);
      directed("t2", 32'h00000000, 32'h01000000, 32'h00000000, 32'h00DDB3D7, 32'hFF224C29, 1'b0);
      directed("t3", 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hD1261481, 1'b1);

      // Back-pressure: output held for 10 cycles, then released.
      out_data_ready = 1'b0;
      send(32'h00000000, 32'h01000000);
      wait_valid("t4", lat);
      repeat (10) tick();
      check1("t4_hold_valid", out_data_valid, 1'b1);
      check1("t4_hold_in_ready", in_data_ready, 1'b0);
      check32("t4_hold_b", phase_b, 32'h00DDB3D7);
      out_data_ready = 1'b1;
      tick();
      check1("t4_drop_valid", out_data_valid, 1'b0);
      check1("t4_in_ready", in_data_ready, 1'b1);
      check32("t4_keep_b", phase_b, 32'h00DDB3D7);

      base = n_out;
      for (int k = 0; k < 8; k++) send(rand_val(), rand_val());
      for (int g = 0; g < 20 && n_out < base + 8; g++) tick();
      check32("t4_stream_count", 32'(n_out - base), 32'd8);

      // Reset while the sample sits in MUL.
      send(32'h01000000, 32'h00000000);
      Resetn = 1'b0;
      tick();
      check1("t5_valid", out_data_valid, 1'b0);
      check1("t5_in_ready", in_data_ready, 1'b0);
      check32("t5_phase_a", phase_a, 32'd0);
      check32("t5_phase_c", phase_c, 32'd0);
      Resetn = 1'b1;
      base = n_out;
      repeat (6) tick();
      check32("t5_no_stale", 32'(n_out - base), 32'd0);
      directed("t5_t1", 32'h01000000, 32'h00000000, 32'h01000000, 32'hFF800000, 32'hFF800000, 1'b0);

      // in_data_valid asserted while busy must be ignored.
      out_data_ready = 1'b0;
      base = n_out;
      send(32'h00000000, 32'h01000000);
      in_data_valid = 1'b1;
      alpha = 32'h12345678;
      beta  = 32'h9ABCDEF0;
      repeat (3) tick();
      in_data_valid = 1'b0;
      check1("t6_valid", out_data_valid, 1'b1);
      check32("t6_b", phase_b, 32'h00DDB3D7);
      out_data_ready = 1'b1;
      repeat (5) tick();
      check32("t6_count", 32'(n_out - base), 32'd1);

      pending = 1'b0;
      for (int i = 0; i < 400; i++) begin
         out_data_ready = ($urandom_range(0, 3) != 0);
         if (!pending && $urandom_range(0, 1) == 1) begin
            pending = 1'b1;
            in_data_valid = 1'b1;
            alpha = rand_val();
            beta  = rand_val();
         end
         hs = in_data_valid && in_data_ready;
         tick();
         if (hs) begin
            pending = 1'b0;
            in_data_valid = 1'b0;
         end
      end
      in_data_valid  = 1'b0;
      out_data_ready = 1'b1;
      repeat (8) tick();
      check32("drain_queue", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
